// File: rtl/us_dist_filter.sv
// Conditioning stage for HC-SR04 distance samples: range rejection, moving average,
// hysteretic obstacle flag and stale detection.
module us_dist_filter #(
  parameter int unsigned DEPTH_LOG2  = 2,
  parameter int unsigned NEAR_MM     = 70,
  parameter int unsigned FAR_MM      = 80,
  parameter int unsigned MAX_MM      = 4000,
  parameter int unsigned TIMEOUT_CYC = 1500000
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic [15:0] dist_in,
  input  logic        dist_valid,
  output logic [15:0] dist_avg,
  output logic        avg_valid,
  output logic        obstacle,
  output logic        stale,
  output logic [7:0]  reject_cnt
);

  localparam int unsigned Depth  = 1 << DEPTH_LOG2;
  localparam int unsigned SumW   = 16 + DEPTH_LOG2;
  localparam int unsigned FillW  = DEPTH_LOG2 + 1;
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [0:0] {StFill, StRun} state_e;

  state_e                  state_q;
  logic [15:0]             sample_buf [Depth];
  logic [SumW-1:0]         sum_q;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q;
  logic [FillW-1:0]        fill_q;
  logic [TimerW-1:0]       timer_q;

  logic                    accept;
  logic                    timeout;
  logic [SumW-1:0]         new_sum;
  logic [15:0]             new_avg;
  logic                    window_full;

  always_comb begin
    accept      = dist_valid && (dist_in != 16'd0) && (dist_in <= 16'(MAX_MM));
    timeout     = !accept && (timer_q == TimerW'(TIMEOUT_CYC - 1));
    // The sum always contains the slot being overwritten, so this never underflows.
    new_sum     = sum_q + SumW'(dist_in) - SumW'(sample_buf[wr_ptr_q]);
    new_avg     = new_sum[SumW-1:DEPTH_LOG2];
    window_full = (state_q == StRun) || (fill_q == FillW'(Depth - 1));
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_q    <= StFill;
      sum_q      <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      timer_q    <= '0;
      dist_avg   <= '0;
      avg_valid  <= 1'b0;
      obstacle   <= 1'b0;
      stale      <= 1'b0;
      reject_cnt <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        sample_buf[i] <= '0;
      end
    end else begin
      avg_valid <= 1'b0;

      if (dist_valid && !accept && (reject_cnt != 8'hff)) begin
        reject_cnt <= reject_cnt + 8'd1;
      end

      if (accept) begin
        sample_buf[wr_ptr_q] <= dist_in;
        sum_q    <= new_sum;
        wr_ptr_q <= wr_ptr_q + 1'b1;
        timer_q  <= '0;
        stale    <= 1'b0;
        if (state_q == StFill) begin
          fill_q <= fill_q + 1'b1;
        end
        if (window_full) begin
          state_q   <= StRun;
          dist_avg  <= new_avg;
          avg_valid <= 1'b1;
          // Between NEAR and FAR the flag holds its previous value.
          if (new_avg < 16'(NEAR_MM)) begin
            obstacle <= 1'b1;
          end else if (new_avg >= 16'(FAR_MM)) begin
            obstacle <= 1'b0;
          end
        end
      end else if (timeout) begin
        // Flush the window; dist_avg and obstacle keep their last values.
        stale    <= 1'b1;
        state_q  <= StFill;
        sum_q    <= '0;
        wr_ptr_q <= '0;
        fill_q   <= '0;
        timer_q  <= '0;
        for (int i = 0; i < int'(Depth); i++) begin
          sample_buf[i] <= '0;
        end
      end else begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_us_dist_filter.sv
// Self-checking bench for us_dist_filter: directed scenarios plus randomized traffic
// against a sliding-window reference model.
module tb_us_dist_filter;

  localparam int Timeout = 1000;
  localparam int N       = 4;
  localparam int Near    = 70;
  localparam int Far     = 80;
  localparam int MaxMm   = 4000;

  logic        clk_50M;
  logic        reset;
  logic [15:0] dist_in;
  logic        dist_valid;
  logic [15:0] dist_avg;
  logic        avg_valid;
  logic        obstacle;
  logic        stale;
  logic [7:0]  reject_cnt;

  int errors;
  int checks;

  // Reference model state
  int win[$];
  int exp_avg;
  int exp_rej;
  int idle;
  bit exp_valid;
  bit exp_obst;
  bit exp_stale;

  us_dist_filter #(
    .DEPTH_LOG2  (2),
    .NEAR_MM     (Near),
    .FAR_MM      (Far),
    .MAX_MM      (MaxMm),
    .TIMEOUT_CYC (Timeout)
  ) dut (
    .clk_50M    (clk_50M),
    .reset      (reset),
    .dist_in    (dist_in),
    .dist_valid (dist_valid),
    .dist_avg   (dist_avg),
    .avg_valid  (avg_valid),
    .obstacle   (obstacle),
    .stale      (stale),
    .reject_cnt (reject_cnt)
  );

  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  function automatic void model_reset();
    win.delete();
    exp_avg   = 0;
    exp_rej   = 0;
    idle      = 0;
    exp_valid = 0;
    exp_obst  = 0;
    exp_stale = 0;
  endfunction

  // Average of the last N accepted samples since the last flush.
  function automatic void model_step(input bit v, input int d);
    bit acc;
    int s;
    acc = v && (d != 0) && (d <= MaxMm);
    exp_valid = 0;
    if (acc) begin
      idle = 0;
      exp_stale = 0;
      win.push_back(d);
      if (win.size() > N) void'(win.pop_front());
      if (win.size() == N) begin
        s = 0;
        foreach (win[i]) s += win[i];
        exp_avg = s / N;
        exp_valid = 1;
        if (exp_avg < Near) exp_obst = 1;
        else if (exp_avg >= Far) exp_obst = 0;
      end
    end else begin
      if (v && exp_rej < 255) exp_rej++;
      idle++;
      if (idle == Timeout) begin
        exp_stale = 1;
        win.delete();
        idle = 0;
      end
    end
  endfunction

  task automatic cycle(input bit v, input logic [15:0] d);
    dist_valid = v;
    dist_in    = d;
    @(posedge clk_50M);
    model_step(v, int'(d));
    #1;
    dist_valid = 1'b0;
    dist_in    = 16'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dist_valid = 1'b0;
    dist_in = 16'd0;
    repeat (3) @(posedge clk_50M);
    #1;
    reset = 1'b0;
    model_reset();
    checks++; if (dist_avg !== 16'd0) begin errors++; $display("FAIL reset_avg got=%0d want=0", dist_avg); end
    checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", avg_valid); end
    checks++; if (obstacle !== 1'b0) begin errors++; $display("FAIL reset_obst got=%b want=0", obstacle); end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL reset_stale got=%b want=0", stale); end
    checks++; if (reject_cnt !== 8'd0) begin errors++; $display("FAIL reset_rej got=%0d want=0", reject_cnt); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 16'd100);
      checks++;
      if (avg_valid !== (k == 3)) begin
        errors++; $display("FAIL fill_valid[%0d] got=%b want=%b", k, avg_valid, (k == 3));
      end
    end
    checks++; if (dist_avg !== 16'd100) begin errors++; $display("FAIL fill_avg got=%0d want=100", dist_avg); end
    checks++; if (obstacle !== 1'b0) begin errors++; $display("FAIL fill_obst got=%b want=0", obstacle); end
    cycle(1'b0, 16'd0);
    checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL pulse_width got=%b want=0", avg_valid); end
  endtask

  task automatic test_back_to_back(input logic [15:0] val, input int exp_a[4], input bit exp_o[4]);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, val);
      checks++; if (avg_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got=%b want=1", k, avg_valid); end
      checks++; if (dist_avg !== 16'(exp_a[k])) begin errors++; $display("FAIL b2b_avg[%0d] got=%0d want=%0d", k, dist_avg, exp_a[k]); end
      checks++; if (obstacle !== exp_o[k]) begin errors++; $display("FAIL b2b_obst[%0d] got=%b want=%b", k, obstacle, exp_o[k]); end
    end
  endtask

  task automatic test_reject();
    cycle(1'b1, 16'd0);
    checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL rej0_valid got=%b want=0", avg_valid); end
    cycle(1'b1, 16'd4001);
    checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL rej4001_valid got=%b want=0", avg_valid); end
    checks++; if (dist_avg !== 16'd100) begin errors++; $display("FAIL rej_avg got=%0d want=100", dist_avg); end
    checks++; if (reject_cnt !== 8'd2) begin errors++; $display("FAIL rej_cnt got=%0d want=2", reject_cnt); end
    repeat (300) begin
      if ($urandom_range(0, 1) == 0) cycle(1'b1, 16'd0);
      else cycle(1'b1, 16'($urandom_range(4001, 65535)));
    end
    checks++; if (reject_cnt !== 8'd255) begin errors++; $display("FAIL rej_sat got=%0d want=255", reject_cnt); end
  endtask

  task automatic test_timeout();
    int remain;
    remain = Timeout - idle;
    for (int i = 1; i <= remain; i++) begin
      cycle(1'b0, 16'd0);
      if (i == remain - 1) begin
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL stale_early got=%b want=0", stale); end
      end
    end
    checks++; if (stale !== 1'b1) begin errors++; $display("FAIL stale_set got=%b want=1", stale); end
    checks++; if (dist_avg !== 16'd100) begin errors++; $display("FAIL stale_avg_hold got=%0d want=100", dist_avg); end
    checks++; if (obstacle !== 1'b0) begin errors++; $display("FAIL stale_obst_hold got=%b want=0", obstacle); end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 16'd200);
      if (k == 0) begin
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL stale_clear got=%b want=0", stale); end
      end
      checks++;
      if (avg_valid !== (k == 3)) begin
        errors++; $display("FAIL refill_valid[%0d] got=%b want=%b", k, avg_valid, (k == 3));
      end
    end
    checks++; if (dist_avg !== 16'd200) begin errors++; $display("FAIL refill_avg got=%0d want=200", dist_avg); end
  endtask

  task automatic test_timeout_race();
    repeat (Timeout - 1) cycle(1'b0, 16'd0);
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL race_pre_stale got=%b want=0", stale); end
    cycle(1'b1, 16'd120);
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL race_stale got=%b want=0", stale); end
    checks++; if (avg_valid !== 1'b1) begin errors++; $display("FAIL race_valid got=%b want=1", avg_valid); end
    checks++; if (dist_avg !== 16'd180) begin errors++; $display("FAIL race_avg got=%0d want=180", dist_avg); end
    cycle(1'b0, 16'd0);
    cycle(1'b1, 16'd120);
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL race_noflush got=%b want=0", stale); end
    checks++; if (dist_avg !== 16'd160) begin errors++; $display("FAIL race_avg2 got=%0d want=160", dist_avg); end
  endtask

  task automatic test_async_reset();
    #4;
    reset = 1'b1;
    #1;
    checks++;
    if ({dist_avg, avg_valid, obstacle, stale, reject_cnt} !== 27'd0) begin
      errors++;
      $display("FAIL async_reset got avg=%0d v=%b o=%b s=%b rej=%0d want all 0",
               dist_avg, avg_valid, obstacle, stale, reject_cnt);
    end
    model_reset();
    dist_valid = 1'b1;
    dist_in = 16'd50;
    @(posedge clk_50M);
    #1;
    dist_valid = 1'b0;
    dist_in = 16'd0;
    reset = 1'b0;
    cycle(1'b1, 16'd150);
    checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got=%b want=0", avg_valid); end
    checks++; if (reject_cnt !== 8'd0) begin errors++; $display("FAIL post_reset_rej got=%0d want=0", reject_cnt); end
  endtask

  task automatic test_random();
    bit v;
    logic [15:0] d;
    int r;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r == 0) d = 16'd0;
      else if (r == 1) d = 16'($urandom_range(4001, 65535));
      else if (r == 2) d = 16'd4000;
      else if (r == 3) d = 16'd1;
      else d = 16'($urandom_range(30, 120));
      cycle(v, d);
      checks++;
      if ({avg_valid, obstacle, stale} !== {exp_valid, exp_obst, exp_stale} ||
          dist_avg !== 16'(exp_avg) || reject_cnt !== 8'(exp_rej)) begin
        errors++;
        $display("FAIL rand[%0d] got v=%b o=%b s=%b avg=%0d rej=%0d want v=%b o=%b s=%b avg=%0d rej=%0d",
                 i, avg_valid, obstacle, stale, dist_avg, reject_cnt,
                 exp_valid, exp_obst, exp_stale, exp_avg, exp_rej);
      end
    end
  endtask

  initial begin
    int fall_a[4] = '{85, 70, 55, 40};
    bit fall_o[4] = '{0, 0, 1, 1};
    int rise_a[4] = '{55, 70, 85, 100};
    bit rise_o[4] = '{1, 1, 0, 0};
    errors = 0;
    checks = 0;
    test_reset();
    test_fill();
    test_back_to_back(16'd40, fall_a, fall_o);
    test_back_to_back(16'd100, rise_a, rise_o);
    test_reject();
    test_timeout();
    test_timeout_race();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
